pipe_wb_regfile: RTL and testbench

- Write-back end of the MEM/WB interface. Consumes the WB-stage control and data (wwreg, wm2reg, wmo, walu, wrn).
- Selects the result, writes it into the 32x32 general register file, and serves the two ID-stage read ports.
- Provides same-cycle write-to-read bypass, so ID sees the value WB is retiring this cycle.
- Keeps a retired-write counter for debug and performance checks.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_regfile_core.sv | 35 +++
 rtl/pipe_wb_regfile.sv | 68 ++++++
 tb/tb_pipe_wb_regfile.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and encodings for the MEM/WB write-back stage and register file.
package pipe_pkg;

    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned CW_DEF   = 32;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        WB_SEL_ALU = 1'b0,
        WB_SEL_MEM = 1'b1
    } wb_sel_e;

endpackage

// File: rtl/pipe_regfile_core.sv
// 2-read/1-write register array with synchronous clear; r0 is never written and always reads 0.
module pipe_regfile_core
    import pipe_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb
);

    logic [DW-1:0] regs [NREG];

    // Reset wins over any write presented on the same edge.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != REG_ZERO)) begin
            regs[wa] <= wd;
        end
    end

    assign qa = (ra == REG_ZERO) ? '0 : regs[ra];
    assign qb = (rb == REG_ZERO) ? '0 : regs[rb];

endmodule

// File: rtl/pipe_wb_regfile.sv
// Write-back stage: result select, register file with same-cycle write-to-read bypass,
// and a counter of committed register writes.
module pipe_wb_regfile
    import pipe_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned CW   = CW_DEF
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          wwreg,
    input  logic          wm2reg,
    input  logic [DW-1:0] wmo,
    input  logic [DW-1:0] walu,
    input  logic [AW-1:0] wrn,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    output logic [DW-1:0] wdata,
    output logic [CW-1:0] wb_count
);

    logic [DW-1:0] arr_qa;
    logic [DW-1:0] arr_qb;
    logic          commit;
    logic          byp_a;
    logic          byp_b;
    logic [CW-1:0] count_q;

    assign wdata  = (wb_sel_e'(wm2reg) == WB_SEL_MEM) ? wmo : walu;
    assign commit = clrn && wwreg && (wrn != REG_ZERO);

    pipe_regfile_core #(
        .NREG (NREG),
        .DW   (DW)
    ) u_core (
        .clk  (clk),
        .clrn (clrn),
        .we   (wwreg),
        .wa   (wrn),
        .wd   (wdata),
        .ra   (rna),
        .rb   (rnb),
        .qa   (arr_qa),
        .qb   (arr_qb)
    );

    // Bypass is suppressed during reset so reads then reflect the stored (cleared) contents.
    assign byp_a = wwreg && clrn && (wrn == rna);
    assign byp_b = wwreg && clrn && (wrn == rnb);

    assign qa = (rna == REG_ZERO) ? '0 : (byp_a ? wdata : arr_qa);
    assign qb = (rnb == REG_ZERO) ? '0 : (byp_b ? wdata : arr_qb);

    // Free-running wrap at 2^CW, no overflow flag.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            count_q <= '0;
        end else if (commit) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign wb_count = count_q;

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// Scoreboard bench for pipe_wb_regfile: driver pushes model predictions, monitor pops and compares.
module tb_pipe_wb_regfile;

    logic        clk = 1'b0;
    logic        clrn;
    logic        wwreg;
    logic        wm2reg;
    logic [31:0] wmo;
    logic [31:0] walu;
    logic [4:0]  wrn;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa, qb, wdata, wb_count;
    logic [31:0] qa4, qb4, wdata4;
    logic [3:0]  wb_count4;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] wd;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: architectural registers and a wide commit counter.
    logic [31:0] ref_regs [32];
    logic [31:0] ref_count;

    always #5 clk = ~clk;

    pipe_wb_regfile u_dut (
        .clk      (clk),
        .clrn     (clrn),
        .wwreg    (wwreg),
        .wm2reg   (wm2reg),
        .wmo      (wmo),
        .walu     (walu),
        .wrn      (wrn),
        .rna      (rna),
        .rnb      (rnb),
        .qa       (qa),
        .qb       (qb),
        .wdata    (wdata),
        .wb_count (wb_count)
    );

    pipe_wb_regfile #(.CW(4)) u_dut4 (
        .clk      (clk),
        .clrn     (clrn),
        .wwreg    (wwreg),
        .wm2reg   (wm2reg),
        .wmo      (wmo),
        .walu     (walu),
        .wrn      (wrn),
        .rna      (rna),
        .rnb      (rnb),
        .qa       (qa4),
        .qb       (qb4),
        .wdata    (wdata4),
        .wb_count (wb_count4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic c, input logic we,
                                             input logic [4:0] wn, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (c && we && (wn == a)) return wd;
        return ref_regs[a];
    endfunction

    // One pipeline cycle: drive, predict, then advance the model across the coming edge.
    task automatic step(input logic c, input logic we, input logic sel, input logic [31:0] mo,
                        input logic [31:0] alu, input logic [4:0] wn, input logic [4:0] a,
                        input logic [4:0] b);
        exp_t e;
        logic [31:0] wd;
        @(posedge clk);
        #1;
        clrn = c; wwreg = we; wm2reg = sel; wmo = mo; walu = alu; wrn = wn; rna = a; rnb = b;
        wd     = sel ? mo : alu;
        e.wd   = wd;
        e.qa   = ref_read(a, c, we, wn, wd);
        e.qb   = ref_read(b, c, we, wn, wd);
        e.cnt  = ref_count;
        e.cnt4 = ref_count[3:0];
        exp_q.push_back(e);
        if (!c) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
            ref_count = 32'd0;
        end else if (we && wn != 5'd0) begin
            ref_regs[wn] = wd;
            ref_count    = ref_count + 32'd1;
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents one response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("qa", qa, e.qa);
                check("qb", qb, e.qb);
                check("wdata", wdata, e.wd);
                check("wb_count", wb_count, e.cnt);
                check("wb_count_cw4", {28'd0, wb_count4}, {28'd0, e.cnt4});
                check("qa_cw4", qa4, e.qa);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  wn, a, b;
        logic [31:0] v;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        ref_count = 32'd0;
        clrn = 1'b0; wwreg = 1'b0; wm2reg = 1'b0; wmo = '0; walu = '0;
        wrn = '0; rna = 5'd5; rnb = 5'd31;
        repeat (2) @(posedge clk);

        // Reset held, reads of non-zero addresses return cleared contents.
        step(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
        step(0, 1, 0, 32'h0, 32'h55, 5'd5, 5'd5, 5'd31);
        // ALU write with bypass, then array read.
        step(1, 1, 0, 32'h0, 32'h1234_5678, 5'd7, 5'd7, 5'd0);
        step(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        // Load select, both ports bypassed.
        step(1, 1, 1, 32'hDEAD_BEEF, 32'h1, 5'd3, 5'd3, 5'd3);
        step(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd7);
        // r0 write discarded.
        step(1, 1, 0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        step(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3);
        // Write colliding with reset is lost.
        step(1, 1, 0, 32'h0, 32'hA5, 5'd9, 5'd9, 5'd0);
        step(0, 1, 0, 32'h0, 32'h77, 5'd9, 5'd9, 5'd9);
        step(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
        // Sixteen commits wrap the 4-bit counter.
        for (int i = 1; i <= 15; i++) begin
            step(1, 1, 0, 32'h0, $urandom, 5'(i), 5'(i), 5'($urandom_range(0, 31)));
        end
        step(1, 1, 1, 32'hC0DE_0001, 32'h0, 5'd1, 5'd2, 5'd15);
        step(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);

        // Random traffic with biased address collisions and rare resets.
        for (int n = 0; n < 600; n++) begin
            wn = 5'($urandom_range(0, 31));
            a  = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
            b  = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
            v  = $urandom;
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)), $urandom, v, wn, a, b);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
